mem2d_ctrl: RTL and testbench

Two-requester controller for the 64x32x8 2D frame memory. Arbitrates read/write transactions from two clients with round-robin priority, drives the memory's address/data/write-enable pins from registers, and returns read data with a fixed latency. Optionally contains a clear engine that sweeps the whole array to a constant value. Sits between the pixel/update clients and the memory array.

---
 rtl/mem2d_ctrl.sv | 158 +++++++++++++++
 tb/tb_mem2d_ctrl.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem2d_ctrl.sv
// mem2d_ctrl: round-robin two-client controller for the 64x32x8 frame memory.
// Optional full-array clear engine is built when MEM2D_CLEAR_EN is defined.
module mem2d_ctrl #(
    parameter int            AW_X      = 6,
    parameter int            AW_Y      = 5,
    parameter int            DW        = 8,
    parameter logic [DW-1:0] CLR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        wr,
    input  logic [2*AW_X-1:0] addr_x,
    input  logic [2*AW_Y-1:0] addr_y,
    input  logic [2*DW-1:0]   wdata,
    output logic [1:0]        gnt,
    output logic [DW-1:0]     rd_data,
    output logic [1:0]        rd_valid,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [AW_X-1:0]   mem_addr_x,
    output logic [AW_Y-1:0]   mem_addr_y,
    output logic [DW-1:0]     mem_wdata,
    output logic              mem_wr,
    input  logic [DW-1:0]     mem_rdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            last_gnt_q, last_gnt_d;
    logic [1:0]      rd_pend_q, rd_pend_d;
    logic [1:0]      rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            clr_busy_q, clr_busy_d;
    logic            clr_done_q, clr_done_d;
    logic [AW_X-1:0] mem_addr_x_q, mem_addr_x_d;
    logic [AW_Y-1:0] mem_addr_y_q, mem_addr_y_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            mem_wr_q, mem_wr_d;
    logic            clr_go;
    logic            sel;
    logic            sweep_last;

`ifdef MEM2D_CLEAR_EN
    assign clr_go = clr_start;
`else
    assign clr_go = 1'b0 & clr_start;
`endif

    // Round-robin grant; a clear start or the CLEAR state blocks every client.
    always_comb begin
        gnt = 2'b00;
        if (state_q == IDLE && !clr_go) begin
            if (req == 2'b11) begin
                gnt = last_gnt_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    assign sel        = gnt[1];
    assign sweep_last = (&mem_addr_x_q) && (&mem_addr_y_q);

    // Next-state: transaction issue, read return pipeline and clear sweep.
    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        mem_addr_x_d = mem_addr_x_q;
        mem_addr_y_d = mem_addr_y_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wr_d     = 1'b0;
        rd_pend_d    = 2'b00;
        rd_valid_d   = rd_pend_q;
        rd_data_d    = (|rd_pend_q) ? mem_rdata : rd_data_q;
        clr_busy_d   = 1'b0;
        clr_done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clr_go) begin
                    state_d      = CLEAR;
                    clr_busy_d   = 1'b1;
                    mem_addr_x_d = '0;
                    mem_addr_y_d = '0;
                    mem_wdata_d  = CLR_VALUE;
                    mem_wr_d     = 1'b1;
                end else if (|gnt) begin
                    last_gnt_d   = sel;
                    mem_addr_x_d = sel ? addr_x[2*AW_X-1:AW_X] : addr_x[AW_X-1:0];
                    mem_addr_y_d = sel ? addr_y[2*AW_Y-1:AW_Y] : addr_y[AW_Y-1:0];
                    mem_wdata_d  = sel ? wdata[2*DW-1:DW] : wdata[DW-1:0];
                    mem_wr_d     = wr[sel];
                    rd_pend_d    = wr[sel] ? 2'b00 : gnt;
                end
            end
            CLEAR: begin
                if (sweep_last) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    clr_busy_d  = 1'b1;
                    mem_wr_d    = 1'b1;
                    mem_wdata_d = CLR_VALUE;
                    if (&mem_addr_y_q) begin
                        mem_addr_y_d = '0;
                        mem_addr_x_d = mem_addr_x_q + 1'b1;
                    end else begin
                        mem_addr_y_d = mem_addr_y_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State and registered outputs; reset aborts any sweep or pending read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_gnt_q   <= 1'b1;
            rd_pend_q    <= 2'b00;
            rd_valid_q   <= 2'b00;
            rd_data_q    <= '0;
            clr_busy_q   <= 1'b0;
            clr_done_q   <= 1'b0;
            mem_addr_x_q <= '0;
            mem_addr_y_q <= '0;
            mem_wdata_q  <= '0;
            mem_wr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            clr_busy_q   <= clr_busy_d;
            clr_done_q   <= clr_done_d;
            mem_addr_x_q <= mem_addr_x_d;
            mem_addr_y_q <= mem_addr_y_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wr_q     <= mem_wr_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign clr_busy   = clr_busy_q;
    assign clr_done   = clr_done_q;
    assign mem_addr_x = mem_addr_x_q;
    assign mem_addr_y = mem_addr_y_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wr     = mem_wr_q;

endmodule

// File: tb/tb_mem2d_ctrl.sv
// tb_mem2d_ctrl: scoreboard bench for mem2d_ctrl with a behavioural frame memory.
// Clear-engine scenarios are selected by MEM2D_CLEAR_EN, matching the DUT build.
module tb_mem2d_ctrl;
    localparam int AW_X = 6;
    localparam int AW_Y = 5;
    localparam int DW = 8;
    localparam logic [7:0] CLR_V = 8'h00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req = '0;
    logic [1:0] wr = '0;
    logic [2*AW_X-1:0] addr_x = '0;
    logic [2*AW_Y-1:0] addr_y = '0;
    logic [2*DW-1:0] wdata = '0;
    logic [1:0] gnt;
    logic [DW-1:0] rd_data;
    logic [1:0] rd_valid;
    logic clr_start = 1'b0;
    logic clr_busy;
    logic clr_done;
    logic [AW_X-1:0] mem_addr_x;
    logic [AW_Y-1:0] mem_addr_y;
    logic [DW-1:0] mem_wdata;
    logic mem_wr;
    logic [DW-1:0] mem_rdata;

    mem2d_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .wr(wr),
        .addr_x(addr_x), .addr_y(addr_y), .wdata(wdata),
        .gnt(gnt), .rd_data(rd_data), .rd_valid(rd_valid),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_addr_x(mem_addr_x), .mem_addr_y(mem_addr_y),
        .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [1:0] mask;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] mem[64][32];
    logic [7:0] ref_mem[64][32];
    logic mem_ready = 1'b0;

    function automatic logic [7:0] pat(int x, int y);
        return 8'((x * 7 + y * 13) ^ 'h5A);
    endfunction

    // Behavioural memory: write on clock, asynchronous read.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_ready) begin
            for (int x = 0; x < 64; x++)
                for (int y = 0; y < 32; y++)
                    mem[x][y] <= pat(x, y);
            mem_ready <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr_x][mem_addr_y] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr_x][mem_addr_y];

    // Read-return monitor against the scoreboard.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            total++;
            if (rd_valid !== sb[0].mask || rd_data !== sb[0].data) begin
                bad++;
                $display("FAIL rd_return: rd_valid=%b rd_data=%h expected %b %h",
                         rd_valid, rd_data, sb[0].mask, sb[0].data);
            end
            void'(sb.pop_front());
        end else if (rd_valid !== 2'b00) begin
            total++;
            bad++;
            $display("FAIL rd_unexpected: rd_valid=%b expected 00", rd_valid);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_req();
        req = 2'b00;
        wr = 2'b00;
    endtask

    task automatic set_req(input int i, input logic w, input int x,
                           input int y, input logic [7:0] d);
        req[i] = 1'b1;
        wr[i] = w;
        addr_x[i*AW_X +: AW_X] = 6'(x);
        addr_y[i*AW_Y +: AW_Y] = 5'(y);
        wdata[i*DW +: DW] = d;
    endtask

    // Sample gnt mid-cycle and record expected effects of accepted transactions.
    task automatic book(output logic [1:0] g);
        int x;
        int y;
        @(negedge clk);
        g = gnt;
        for (int i = 0; i < 2; i++) begin
            if (g[i]) begin
                x = int'(addr_x[i*AW_X +: AW_X]);
                y = int'(addr_y[i*AW_Y +: AW_Y]);
                if (wr[i]) ref_mem[x][y] = wdata[i*DW +: DW];
                else sb.push_back('{cyc + 2, 2'(1 << i), ref_mem[x][y]});
            end
        end
    endtask

    task automatic test_reset();
        logic [1:0] g;
        rst = 1'b1;
        idle_req();
        clr_start = 1'b0;
        sb.delete();
        tick();
        tick();
        book(g);
        total++;
        if ({g, rd_valid, rd_data, clr_busy, clr_done, mem_addr_x,
             mem_addr_y, mem_wdata, mem_wr} !== '0) begin
            bad++;
            $display("FAIL reset_state: gnt=%b rv=%b rd=%h busy=%b done=%b ax=%0d ay=%0d wd=%h wr=%b expected all 0",
                     g, rd_valid, rd_data, clr_busy, clr_done, mem_addr_x,
                     mem_addr_y, mem_wdata, mem_wr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [1:0] g;
        set_req(0, 1'b1, 5, 3, 8'hA5);
        book(g);
        total++;
        if (g !== 2'b01) begin
            bad++;
            $display("FAIL basic_wr_gnt: got %b expected 01", g);
        end
        tick();
        idle_req();
        @(negedge clk);
        total++;
        if ({mem_wr, mem_addr_x, mem_addr_y, mem_wdata} !== {1'b1, 6'd5, 5'd3, 8'hA5}) begin
            bad++;
            $display("FAIL basic_wr_pins: wr=%b ax=%0d ay=%0d wd=%h expected 1 5 3 a5",
                     mem_wr, mem_addr_x, mem_addr_y, mem_wdata);
        end
        tick();
        set_req(0, 1'b0, 5, 3, 8'h00);
        book(g);
        total++;
        if (g !== 2'b01 || mem_wr !== 1'b0) begin
            bad++;
            $display("FAIL basic_rd_gnt: gnt=%b mem_wr=%b expected 01 0", g, mem_wr);
        end
        tick();
        idle_req();
        tick();
        @(negedge clk);
        total++;
        if (rd_valid !== 2'b01 || rd_data !== 8'hA5) begin
            bad++;
            $display("FAIL basic_rd_data: rv=%b rd=%h expected 01 a5", rd_valid, rd_data);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] g;
        logic [1:0] e;
        set_req(0, 1'b0, 1, 2, 8'h00);
        set_req(1, 1'b0, 40, 20, 8'h00);
        for (int k = 0; k < 4; k++) begin
            book(g);
            e = (k % 2 == 0) ? 2'b01 : 2'b10;
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL rr_order[%0d]: got %b expected %b", k, g, e);
            end
            tick();
        end
        idle_req();
        repeat (3) tick();
    endtask

    task automatic test_corner();
        logic [1:0] g;
        set_req(1, 1'b1, 63, 31, 8'h3C);
        book(g);
        total++;
        if (g !== 2'b10) begin
            bad++;
            $display("FAIL corner_wr_gnt: got %b expected 10", g);
        end
        tick();
        idle_req();
        set_req(0, 1'b0, 63, 31, 8'h00);
        book(g);
        total++;
        if (g !== 2'b01) begin
            bad++;
            $display("FAIL corner_rd_gnt: got %b expected 01", g);
        end
        tick();
        idle_req();
        tick();
        @(negedge clk);
        total++;
        if (rd_valid !== 2'b01 || rd_data !== 8'h3C) begin
            bad++;
            $display("FAIL corner_rd_data: rv=%b rd=%h expected 01 3c", rd_valid, rd_data);
        end
        tick();
    endtask

    task automatic test_read_abort();
        logic [1:0] g;
        set_req(0, 1'b0, 5, 3, 8'h00);
        book(g);
        total++;
        if (g !== 2'b01) begin
            bad++;
            $display("FAIL abort_rd_gnt: got %b expected 01", g);
        end
        tick();
        idle_req();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rd_valid !== 2'b00 || rd_data !== 8'h00) begin
            bad++;
            $display("FAIL abort_no_rd: rv=%b rd=%h expected 00 00", rd_valid, rd_data);
        end
        tick();
    endtask

`ifdef MEM2D_CLEAR_EN
    task automatic test_clear();
        logic [1:0] g;
        logic [1:0] g2;
        int errs;
        set_req(0, 1'b0, 0, 0, 8'h00);
        set_req(1, 1'b0, 31, 15, 8'h00);
        clr_start = 1'b1;
        book(g);
        total++;
        if (g !== 2'b00) begin
            bad++;
            $display("FAIL clr_start_gnt: got %b expected 00", g);
        end
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
                ref_mem[x][y] = CLR_V;
        tick();
        clr_start = 1'b0;
        errs = 0;
        for (int k = 0; k < 2048; k++) begin
            @(negedge clk);
            if (gnt !== 2'b00 || clr_busy !== 1'b1 || clr_done !== 1'b0 ||
                mem_wr !== 1'b1 || mem_addr_x !== 6'(k / 32) ||
                mem_addr_y !== 5'(k % 32) || mem_wdata !== CLR_V)
                errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL clear_sweep: bad_cycles=%0d expected 0", errs);
        end
        book(g);
        total++;
        if (clr_done !== 1'b1 || clr_busy !== 1'b0 || g !== 2'b01) begin
            bad++;
            $display("FAIL clear_done: done=%b busy=%b gnt=%b expected 1 0 01",
                     clr_done, clr_busy, g);
        end
        tick();
        req = req & ~g;
        book(g2);
        total++;
        if (g2 !== 2'b10 || clr_done !== 1'b0) begin
            bad++;
            $display("FAIL clear_resume: gnt=%b done=%b expected 10 0", g2, clr_done);
        end
        tick();
        idle_req();
        set_req(0, 1'b0, 63, 31, 8'h00);
        book(g);
        total++;
        if (g !== 2'b01) begin
            bad++;
            $display("FAIL clear_rd_corner_gnt: got %b expected 01", g);
        end
        tick();
        idle_req();
        repeat (4) tick();
    endtask

    task automatic test_clear_abort();
        logic [1:0] g;
        int errs;
        idle_req();
        clr_start = 1'b1;
        book(g);
        tick();
        clr_start = 1'b0;
        repeat (999) tick();
        @(negedge clk);
        total++;
        if (clr_busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_mid_busy: got %b expected 1", clr_busy);
        end
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({gnt, rd_valid, rd_data, clr_busy, clr_done, mem_addr_x,
             mem_addr_y, mem_wdata, mem_wr} !== '0) begin
            bad++;
            $display("FAIL abort_outputs: gnt=%b rv=%b busy=%b done=%b ax=%0d ay=%0d wr=%b expected all 0",
                     gnt, rd_valid, clr_busy, clr_done, mem_addr_x, mem_addr_y, mem_wr);
        end
        errs = 0;
        for (int k = 0; k < 2100; k++) begin
            tick();
            @(negedge clk);
            if (clr_done !== 1'b0 || clr_busy !== 1'b0 || mem_wr !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL abort_no_done: bad_cycles=%0d expected 0", errs);
        end
        tick();
        set_req(0, 1'b1, 7, 7, 8'h77);
        book(g);
        tick();
        idle_req();
        set_req(0, 1'b0, 7, 7, 8'h00);
        book(g);
        total++;
        if (g !== 2'b01) begin
            bad++;
            $display("FAIL abort_serve: got %b expected 01", g);
        end
        tick();
        idle_req();
        repeat (4) tick();
    endtask
`else
    task automatic test_noclear();
        logic [1:0] g;
        int errs;
        set_req(0, 1'b0, 20, 10, 8'h00);
        clr_start = 1'b1;
        book(g);
        total++;
        if (g !== 2'b01) begin
            bad++;
            $display("FAIL noclr_gnt: got %b expected 01", g);
        end
        tick();
        clr_start = 1'b0;
        idle_req();
        set_req(1, 1'b0, 9, 9, 8'h00);
        book(g);
        total++;
        if (g !== 2'b10 || clr_busy !== 1'b0) begin
            bad++;
            $display("FAIL noclr_next: gnt=%b busy=%b expected 10 0", g, clr_busy);
        end
        tick();
        idle_req();
        errs = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (clr_busy !== 1'b0 || clr_done !== 1'b0 || mem_wr !== 1'b0) errs++;
            tick();
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL noclr_idle: bad_cycles=%0d expected 0", errs);
        end
    endtask
`endif

    initial begin
        for (int x = 0; x < 64; x++)
            for (int y = 0; y < 32; y++)
                ref_mem[x][y] = pat(x, y);
        test_reset();
        test_basic();
        test_reset();
        test_contention();
        test_corner();
        test_read_abort();
`ifdef MEM2D_CLEAR_EN
        test_clear();
        test_clear_abort();
`else
        test_noclear();
`endif
        repeat (5) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
